otter_hazard_unit: RTL and testbench
====================================

OTTER_HAZARD_UNIT -- requirements
Module: otter_hazard_unit

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter LOAD_LAT, default 1, load-use stall cycles inserted (legal 1..4).
REQ-003 SHALL have parameter CNT_W, default 32, performance-counter width.
REQ-004 SHALL have one clock and asynchronous active-low reset: CLK  in  1  clock, rising edge; RESET_N  in  1  async active-low reset.
REQ-005 SHALL have de_rs1_addr/de_rs2_addr  in  REG_AW each  DE-stage source registers; de_rs1_used/de_rs2_used  in  1 each  source actually read.
REQ-006 SHALL have ex_rd_addr  in  REG_AW; ex_regWrite, ex_memRead, ex_valid  in  1 each  DE/EX register contents.
REQ-007 SHALL have mem_rd_addr  in  REG_AW; mem_regWrite, mem_valid  in  1 each  EX/MEM register contents.
REQ-008 SHALL have wb_rd_addr  in  REG_AW; wb_regWrite, wb_valid  in  1 each  MEM/WB register contents.
REQ-009 SHALL have ex_redirect  in  1  taken branch/JAL/JALR resolved in EX; hold  in  1  external freeze (memory wait).
REQ-010 SHALL have pc_stall, if_de_stall, de_ex_bubble, if_de_flush, de_ex_flush  out  1 each  pipeline controls.
REQ-011 SHALL have fwd_a_sel, fwd_b_sel  out  2 each  operand source: 00 regfile, 01 EX/MEM aluRes, 10 MEM/WB write-back data.
REQ-012 SHALL have stall_cnt, flush_cnt, hold_cnt  out  CNT_W each  performance counters.

Function
REQ-013 SHALL compute forwarding combinationally: 01 when mem_valid & mem_regWrite & mem_rd_addr==src & src!=0; else 10 when wb_valid & wb_regWrite & wb_rd_addr==src & src!=0; else 00; EX/MEM takes priority over MEM/WB.
REQ-014 SHALL force fwd select 00 when the corresponding de_rsN_used is 0.
REQ-015 SHALL detect load-use when ex_valid & ex_memRead & ex_rd_addr!=0 & ex_rd_addr matches a used DE source.
REQ-016 SHALL implement FSM states RUN and LU_STALL with a down-counter of width clog2(LOAD_LAT+1).
REQ-017 In RUN, on load-use with ex_redirect=0 and hold=0: assert pc_stall, if_de_stall, de_ex_bubble same cycle; if LOAD_LAT>1 enter LU_STALL with counter=LOAD_LAT-1, else stay RUN.
REQ-018 In LU_STALL: assert pc_stall, if_de_stall, de_ex_bubble; decrement counter; return to RUN in the cycle counter reaches 1 (total stall = LOAD_LAT cycles).
REQ-019 ex_redirect SHALL assert if_de_flush and de_ex_flush same cycle, deassert all stall outputs, force RUN, clear counter; redirect overrides load-use and LU_STALL.
REQ-020 hold=1 SHALL assert pc_stall and if_de_stall, deassert de_ex_bubble and both flushes, freeze FSM state and counter; hold overrides redirect (redirect must be re-presented after hold).
REQ-021 stall_cnt SHALL increment each cycle de_ex_bubble=1; flush_cnt each cycle if_de_flush=1; hold_cnt each cycle hold=1.
REQ-022 All counters SHALL saturate at all-ones, never wrap.
REQ-023 Outputs other than counters SHALL be purely combinational from inputs and FSM state; no output latency beyond that.

Reset
REQ-024 RESET_N low SHALL asynchronously force RUN, stall counter 0, stall_cnt/flush_cnt/hold_cnt 0.
REQ-025 During reset all stall/flush/bubble outputs SHALL be 0; fwd selects follow REQ-013 rules.
REQ-026 Reset asserted mid-LU_STALL SHALL abort the stall; first cycle after release is RUN.

Structure
REQ-027 fwd-select encodings and FSM state enum SHALL reside in the shared otter_pkg package alongside opcode_t and instr_t.
REQ-028 SHALL instantiate one sub-module otter_sat_counter (parametrised CNT_W, inc, async active-low reset) three times.

Verification
REQ-029 EX/MEM rd=5 regWrite, DE rs1=5 used -> fwd_a_sel=01; same with MEM/WB rd=5 also -> still 01.
REQ-030 DE rs2=0 used, EX/MEM rd=0 regWrite -> fwd_b_sel=00.
REQ-031 LOAD_LAT=3, EX load rd=7, DE rs1=7 -> exactly 3 consecutive cycles of pc_stall/de_ex_bubble, stall_cnt=3.
REQ-032 Load-use and ex_redirect same cycle -> flushes=1, stalls=0, flush_cnt=1, FSM RUN.
REQ-033 LOAD_LAT=3, hold=1 for 2 cycles during LU_STALL -> bubble total still 3, hold_cnt=2.
REQ-034 CNT_W=4, 20 redirect cycles -> flush_cnt=15; RESET_N low mid-stall -> all outputs 0 immediately.

Source files
------------

// File: rtl/otter_pkg.sv
// Shared OTTER core types: opcodes, instruction layout, and hazard-unit encodings.
package otter_pkg;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011,
    OP_SYS    = 7'b1110011
  } opcode_t;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    opcode_t    opcode;
  } instr_t;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } hz_state_t;

  // The younger result (EX/MEM) wins; x0 never forwards.
  function automatic fwd_sel_t fwd_pick(input logic used, input logic src_nz,
                                        input logic mem_hit, input logic wb_hit);
    fwd_sel_t sel;
    sel = FWD_RF;
    if (used && src_nz) begin
      if (mem_hit)     sel = FWD_EXMEM;
      else if (wb_hit) sel = FWD_MEMWB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/otter_sat_counter.sv
// Saturating up-counter; sticks at all-ones instead of wrapping.
module otter_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)                count <= '0;
    else if (inc && !(&count))   count <= count + 1'b1;
  end

endmodule

// File: rtl/otter_hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use stall FSM, redirect flush,
// external hold, and saturating performance counters.
module otter_hazard_unit
  import otter_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [REG_AW-1:0] de_rs1_addr,
  input  logic [REG_AW-1:0] de_rs2_addr,
  input  logic              de_rs1_used,
  input  logic              de_rs2_used,
  input  logic [REG_AW-1:0] ex_rd_addr,
  input  logic              ex_regWrite,
  input  logic              ex_memRead,
  input  logic              ex_valid,
  input  logic [REG_AW-1:0] mem_rd_addr,
  input  logic              mem_regWrite,
  input  logic              mem_valid,
  input  logic [REG_AW-1:0] wb_rd_addr,
  input  logic              wb_regWrite,
  input  logic              wb_valid,
  input  logic              ex_redirect,
  input  logic              hold,
  output logic              pc_stall,
  output logic              if_de_stall,
  output logic              de_ex_bubble,
  output logic              if_de_flush,
  output logic              de_ex_flush,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [CNT_W-1:0]  hold_cnt
);

  localparam int              SW     = $clog2(LOAD_LAT + 1);
  localparam logic [SW-1:0]   RELOAD = SW'(LOAD_LAT - 1);

  hz_state_t     state;
  logic [SW-1:0] lu_cnt;
  logic          mem_wr, wb_wr, load_use;

  assign mem_wr = mem_valid & mem_regWrite;
  assign wb_wr  = wb_valid  & wb_regWrite;

  assign fwd_a_sel = fwd_pick(de_rs1_used, de_rs1_addr != '0,
                              mem_wr && (mem_rd_addr == de_rs1_addr),
                              wb_wr  && (wb_rd_addr  == de_rs1_addr));
  assign fwd_b_sel = fwd_pick(de_rs2_used, de_rs2_addr != '0,
                              mem_wr && (mem_rd_addr == de_rs2_addr),
                              wb_wr  && (wb_rd_addr  == de_rs2_addr));

  assign load_use = ex_valid && ex_memRead && (ex_rd_addr != '0) &&
                    ((de_rs1_used && (de_rs1_addr == ex_rd_addr)) ||
                     (de_rs2_used && (de_rs2_addr == ex_rd_addr)));

  // Priority: reset > hold > redirect > ongoing stall > new load-use.
  always_comb begin
    pc_stall     = 1'b0;
    if_de_stall  = 1'b0;
    de_ex_bubble = 1'b0;
    if_de_flush  = 1'b0;
    de_ex_flush  = 1'b0;
    if (RESET_N) begin
      if (hold) begin
        pc_stall    = 1'b1;
        if_de_stall = 1'b1;
      end else if (ex_redirect) begin
        if_de_flush = 1'b1;
        de_ex_flush = 1'b1;
      end else if (state == LU_STALL || load_use) begin
        pc_stall     = 1'b1;
        if_de_stall  = 1'b1;
        de_ex_bubble = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= RUN;
      lu_cnt <= '0;
    end else if (!hold) begin
      if (ex_redirect) begin
        state  <= RUN;
        lu_cnt <= '0;
      end else begin
        case (state)
          RUN: if (load_use && LOAD_LAT > 1) begin
            state  <= LU_STALL;
            lu_cnt <= RELOAD;
          end
          LU_STALL: begin
            lu_cnt <= lu_cnt - SW'(1);
            if (lu_cnt == SW'(1)) state <= RUN;
          end
          default: state <= RUN;
        endcase
      end
    end
  end

  logic [2:0]            cnt_inc;
  logic [2:0][CNT_W-1:0] cnt_val;

  assign cnt_inc = {hold, if_de_flush, de_ex_bubble};

  for (genvar g = 0; g < 3; g++) begin : g_cnt
    otter_sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .inc     (cnt_inc[g]),
      .count   (cnt_val[g])
    );
  end

  assign stall_cnt = cnt_val[0];
  assign flush_cnt = cnt_val[1];
  assign hold_cnt  = cnt_val[2];

endmodule

// File: tb/tb_otter_hazard_unit.sv
// Directed checks of forwarding, load-use stall, redirect, hold, counters and reset.
module tb_otter_hazard_unit;

  localparam int REG_AW   = 5;
  localparam int LOAD_LAT = 3;
  localparam int CNT_W    = 4;

  logic              CLK, RESET_N;
  logic [REG_AW-1:0] de_rs1_addr, de_rs2_addr, ex_rd_addr, mem_rd_addr, wb_rd_addr;
  logic              de_rs1_used, de_rs2_used;
  logic              ex_regWrite, ex_memRead, ex_valid;
  logic              mem_regWrite, mem_valid, wb_regWrite, wb_valid;
  logic              ex_redirect, hold;
  logic              pc_stall, if_de_stall, de_ex_bubble, if_de_flush, de_ex_flush;
  logic [1:0]        fwd_a_sel, fwd_b_sel;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt, hold_cnt;

  int checks = 0;
  int errors = 0;

  otter_hazard_unit #(.REG_AW(REG_AW), .LOAD_LAT(LOAD_LAT), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .de_rs1_addr(de_rs1_addr), .de_rs2_addr(de_rs2_addr),
    .de_rs1_used(de_rs1_used), .de_rs2_used(de_rs2_used),
    .ex_rd_addr(ex_rd_addr), .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead),
    .ex_valid(ex_valid),
    .mem_rd_addr(mem_rd_addr), .mem_regWrite(mem_regWrite), .mem_valid(mem_valid),
    .wb_rd_addr(wb_rd_addr), .wb_regWrite(wb_regWrite), .wb_valid(wb_valid),
    .ex_redirect(ex_redirect), .hold(hold),
    .pc_stall(pc_stall), .if_de_stall(if_de_stall), .de_ex_bubble(de_ex_bubble),
    .if_de_flush(if_de_flush), .de_ex_flush(de_ex_flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .hold_cnt(hold_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr_inputs();
    de_rs1_addr = '0; de_rs2_addr = '0; de_rs1_used = 1'b0; de_rs2_used = 1'b0;
    ex_rd_addr = '0; ex_regWrite = 1'b0; ex_memRead = 1'b0; ex_valid = 1'b0;
    mem_rd_addr = '0; mem_regWrite = 1'b0; mem_valid = 1'b0;
    wb_rd_addr = '0; wb_regWrite = 1'b0; wb_valid = 1'b0;
    ex_redirect = 1'b0; hold = 1'b0;
  endtask

  task automatic do_reset();
    clr_inputs();
    RESET_N = 1'b0;
    tick();
    tick();
    RESET_N = 1'b1;
    #1;
  endtask

  task automatic set_load7();
    ex_valid = 1'b1; ex_memRead = 1'b1; ex_regWrite = 1'b1; ex_rd_addr = 5'd7;
    de_rs1_addr = 5'd7; de_rs1_used = 1'b1;
  endtask

  initial begin
    clr_inputs();
    RESET_N = 1'b0;
    #3;
    chk("rst_pc_stall", 32'(pc_stall), 0);
    chk("rst_bubble",   32'(de_ex_bubble), 0);
    chk("rst_stall_cnt", 32'(stall_cnt), 0);
    chk("rst_flush_cnt", 32'(flush_cnt), 0);
    tick();
    RESET_N = 1'b1;
    #1;

    // Forwarding priority and gating
    de_rs1_addr = 5'd5; de_rs1_used = 1'b1;
    mem_rd_addr = 5'd5; mem_regWrite = 1'b1; mem_valid = 1'b1;
    #1 chk("fwd_a_exmem", 32'(fwd_a_sel), 32'h1);
    wb_rd_addr = 5'd5; wb_regWrite = 1'b1; wb_valid = 1'b1;
    #1 chk("fwd_a_exmem_prio", 32'(fwd_a_sel), 32'h1);
    mem_valid = 1'b0;
    #1 chk("fwd_a_memwb", 32'(fwd_a_sel), 32'h2);
    de_rs1_used = 1'b0;
    #1 chk("fwd_a_unused", 32'(fwd_a_sel), 32'h0);
    clr_inputs();
    de_rs2_addr = 5'd0; de_rs2_used = 1'b1;
    mem_rd_addr = 5'd0; mem_regWrite = 1'b1; mem_valid = 1'b1;
    #1 chk("fwd_b_x0", 32'(fwd_b_sel), 32'h0);
    de_rs2_addr = 5'd9; mem_rd_addr = 5'd9;
    #1 chk("fwd_b_exmem", 32'(fwd_b_sel), 32'h1);

    // Load-use: exactly LOAD_LAT stall cycles
    do_reset();
    set_load7();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("lu_bubble_%0d", i), 32'(de_ex_bubble), (i < 3) ? 1 : 0);
      chk($sformatf("lu_pc_stall_%0d", i), 32'(pc_stall), (i < 3) ? 1 : 0);
      tick();
      if (i == 0) ex_valid = 1'b0;
    end
    chk("lu_stall_cnt", 32'(stall_cnt), 3);

    // Redirect overrides load-use
    do_reset();
    set_load7();
    ex_redirect = 1'b1;
    #1;
    chk("rd_if_de_flush", 32'(if_de_flush), 1);
    chk("rd_de_ex_flush", 32'(de_ex_flush), 1);
    chk("rd_pc_stall", 32'(pc_stall), 0);
    chk("rd_bubble", 32'(de_ex_bubble), 0);
    tick();
    ex_redirect = 1'b0; ex_valid = 1'b0;
    #1;
    chk("rd_flush_cnt", 32'(flush_cnt), 1);
    chk("rd_state_run", 32'(pc_stall), 0);
    chk("rd_stall_cnt", 32'(stall_cnt), 0);

    // Hold freezes LU_STALL; bubbles still total LOAD_LAT
    do_reset();
    set_load7();
    #1 chk("hd_bubble0", 32'(de_ex_bubble), 1);
    tick();
    ex_valid = 1'b0;
    hold = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk($sformatf("hd_pc_stall_%0d", i), 32'(pc_stall), 1);
      chk($sformatf("hd_bubble_h%0d", i), 32'(de_ex_bubble), 0);
      tick();
    end
    hold = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("hd_bubble_r%0d", i), 32'(de_ex_bubble), (i < 2) ? 1 : 0);
      tick();
    end
    chk("hd_stall_cnt", 32'(stall_cnt), 3);
    chk("hd_hold_cnt", 32'(hold_cnt), 2);
    hold = 1'b1; ex_redirect = 1'b1;
    #1;
    chk("hd_over_rd_flush", 32'(if_de_flush), 0);
    chk("hd_over_rd_stall", 32'(if_de_stall), 1);
    tick();
    clr_inputs();

    // Counter saturation, then reset mid-stall
    do_reset();
    ex_redirect = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    ex_redirect = 1'b0;
    chk("sat_flush_cnt", 32'(flush_cnt), 15);
    set_load7();
    tick();
    ex_valid = 1'b0;
    #1 chk("mid_stall_active", 32'(pc_stall), 1);
    mem_rd_addr = 5'd7; mem_regWrite = 1'b1; mem_valid = 1'b1;
    hold = 1'b1;
    RESET_N = 1'b0;
    #1;
    chk("rst_mid_pc_stall", 32'(pc_stall), 0);
    chk("rst_mid_if_de_stall", 32'(if_de_stall), 0);
    chk("rst_mid_bubble", 32'(de_ex_bubble), 0);
    chk("rst_mid_flush", 32'(if_de_flush), 0);
    chk("rst_mid_flush_cnt", 32'(flush_cnt), 0);
    chk("rst_mid_stall_cnt", 32'(stall_cnt), 0);
    chk("rst_mid_fwd_a", 32'(fwd_a_sel), 32'h1);
    tick();
    hold = 1'b0;
    #1 chk("rst_mid_hold_cnt", 32'(hold_cnt), 0);
    RESET_N = 1'b1;
    #1 chk("post_rst_run", 32'(pc_stall), 0);
    tick();
    chk("post_rst_run2", 32'(pc_stall), 0);
    chk("post_rst_stall_cnt", 32'(stall_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
